systolic_ctrl: RTL and testbench

Sequencer for an N×N systolic array of signed W-bit multiply-accumulate units. It runs a whole job. First it loads one weight row per handshake into the array's per-unit weight registers. It then streams input vectors into the array's right edge with the row skew the array needs, generating the shared `step` enable. It then drains the pipeline and flags which bottom-row results are valid. It sits between the host/DMA streams and the array, and gives a JTAG stall input priority over streaming so array state can be read while frozen.

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/systolic_ctrl_skew.sv | 35 +++
 rtl/systolic_ctrl.sv | 152 +++++++++++++++
 tb/tb_systolic_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_W = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } ctrl_state_t;

   localparam int W_DEF = 8;
   localparam int N_DEF = 4;

   // Steps needed to flush the last real vector out of the bottom-left unit.
   function automatic int drain_steps(input int n);
      return 2 * n - 1;
   endfunction

endpackage

// File: rtl/systolic_ctrl_skew.sv
// Step-enabled, clearable delay line feeding one row of the array's right edge.
module skew_line #(
   parameter int W     = 8,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   if (DEPTH == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst_n, en, clr};
      assign q = d;
   end else begin : g_reg
      logic [W-1:0] sr [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
         end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
         end else if (en) begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
         end
      end

      assign q = sr[DEPTH-1];
   end

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for an NxN systolic MAC array: weight load, skewed streaming,
// drain with result-valid tags, JTAG halt and abort.
module systolic_ctrl
   import systolic_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int N     = N_DEF,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [CNT_W-1:0] vec_cnt_i,
   input  logic             abort_i,
   input  logic             halt_i,
   input  logic             w_valid_i,
   output logic             w_ready_o,
   input  logic [N*W-1:0]   w_data_i,
   input  logic             x_valid_i,
   output logic             x_ready_o,
   input  logic [N*W-1:0]   x_data_i,
   output logic [N-1:0]     wr_weight_v_o,
   output logic [N*W-1:0]   weight_o,
   output logic             step_o,
   output logic [N*W-1:0]   data_o,
   output logic [N-1:0]     res_valid_o,
   output logic             busy_o,
   output logic             done_o,
   output ctrl_state_t      state_o
);

   localparam int RW      = (N > 1) ? $clog2(N) : 1;
   localparam int DRAIN_N = drain_steps(N);
   localparam int DW      = $clog2(DRAIN_N + 1);
   localparam int TAG_D   = 2 * N - 1;

   ctrl_state_t      state;
   logic [RW-1:0]    row_cnt;
   logic [CNT_W-1:0] rem_cnt;
   logic [DW-1:0]    drain_cnt;
   logic [TAG_D-1:0] tag_sr;
   logic [N*W-1:0]   inject;
   logic             tag_in;
   logic             w_fire;

   // Handshakes: a beat transfers on a cycle where valid and ready are both
   // high; ready never depends on valid, and abort or halt force ready low.
   assign state_o   = state;
   assign busy_o    = (state != IDLE);
   assign w_ready_o = (state == LOAD_W) && !halt_i && !abort_i;
   assign w_fire    = w_ready_o && w_valid_i;
   // The last weight row is written into the array on the edge ending the
   // cycle where wr_weight_v_o is high, so streaming waits for it.
   assign x_ready_o = (state == STREAM) && !halt_i && !abort_i && (wr_weight_v_o == '0);
   assign tag_in    = (state == STREAM);
   assign inject    = (state == STREAM) ? x_data_i : '0;

   always_comb begin
      step_o = 1'b0;
      case (state)
         STREAM:  step_o = x_valid_i && x_ready_o;
         DRAIN:   step_o = !halt_i && !abort_i;
         default: step_o = 1'b0;
      endcase
   end

   always_comb begin
      res_valid_o = '0;
      for (int c = 0; c < N; c++) res_valid_o[c] = step_o & tag_sr[TAG_D-1-c];
   end

   for (genvar r = 0; r < N; r++) begin : g_row
      skew_line #(.W(W), .DEPTH(r)) u_skew (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (step_o),
         .clr   (abort_i),
         .d     (inject[r*W +: W]),
         .q     (data_o[r*W +: W])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         row_cnt       <= '0;
         rem_cnt       <= '0;
         drain_cnt     <= '0;
         tag_sr        <= '0;
         wr_weight_v_o <= '0;
         weight_o      <= '0;
         done_o        <= 1'b0;
      end else if (abort_i && state != IDLE) begin
         state         <= IDLE;
         row_cnt       <= '0;
         rem_cnt       <= '0;
         drain_cnt     <= '0;
         tag_sr        <= '0;
         wr_weight_v_o <= '0;
         weight_o      <= '0;
         done_o        <= 1'b0;
      end else begin
         wr_weight_v_o <= '0;
         weight_o      <= '0;
         done_o        <= 1'b0;
         if (step_o) tag_sr <= {tag_sr[TAG_D-2:0], tag_in};
         case (state)
            IDLE: begin
               if (start_i && vec_cnt_i != '0) begin
                  rem_cnt   <= vec_cnt_i;
                  row_cnt   <= '0;
                  drain_cnt <= '0;
                  state     <= LOAD_W;
               end
            end
            LOAD_W: begin
               if (w_fire) begin
                  wr_weight_v_o <= N'(1) << row_cnt;
                  weight_o      <= w_data_i;
                  if (row_cnt == RW'(N - 1)) begin
                     row_cnt <= '0;
                     state   <= STREAM;
                  end else begin
                     row_cnt <= row_cnt + RW'(1);
                  end
               end
            end
            STREAM: begin
               if (step_o) begin
                  rem_cnt <= rem_cnt - CNT_W'(1);
                  if (rem_cnt == CNT_W'(1)) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (step_o) begin
                  if (drain_cnt != DW'(DRAIN_N)) drain_cnt <= drain_cnt + DW'(1);
                  if (drain_cnt == DW'(DRAIN_N - 1)) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end
               end
            end
            DONE: begin
               drain_cnt <= '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl: cycle table for a full job plus
// hand-written reset, halt, abort and ignored-start sequences.
module tb_systolic_ctrl;
   import systolic_pkg::*;

   localparam int W     = 8;
   localparam int N     = 4;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start_i;
   logic [CNT_W-1:0] vec_cnt_i;
   logic             abort_i;
   logic             halt_i;
   logic             w_valid_i;
   logic             w_ready_o;
   logic [N*W-1:0]   w_data_i;
   logic             x_valid_i;
   logic             x_ready_o;
   logic [N*W-1:0]   x_data_i;
   logic [N-1:0]     wr_weight_v_o;
   logic [N*W-1:0]   weight_o;
   logic             step_o;
   logic [N*W-1:0]   data_o;
   logic [N-1:0]     res_valid_o;
   logic             busy_o;
   logic             done_o;
   ctrl_state_t      state_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   systolic_ctrl #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .vec_cnt_i     (vec_cnt_i),
      .abort_i       (abort_i),
      .halt_i        (halt_i),
      .w_valid_i     (w_valid_i),
      .w_ready_o     (w_ready_o),
      .w_data_i      (w_data_i),
      .x_valid_i     (x_valid_i),
      .x_ready_o     (x_ready_o),
      .x_data_i      (x_data_i),
      .wr_weight_v_o (wr_weight_v_o),
      .weight_o      (weight_o),
      .step_o        (step_o),
      .data_o        (data_o),
      .res_valid_o   (res_valid_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .state_o       (state_o)
   );

   typedef struct {
      logic         start;
      logic         wv;
      logic [31:0]  wd;
      logic         xv;
      logic [31:0]  xd;
      logic         e_step;
      logic [3:0]   e_wv;
      logic [31:0]  e_wo;
      logic [31:0]  e_data;
      logic [3:0]   e_rv;
      logic         e_done;
      logic         e_busy;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic start, input logic wv, input logic [31:0] wd,
                               input logic xv, input logic [31:0] xd, input logic e_step,
                               input logic [3:0] e_wv, input logic [31:0] e_wo,
                               input logic [31:0] e_data, input logic [3:0] e_rv,
                               input logic e_done, input logic e_busy);
      vec_t v;
      v.start = start; v.wv = wv; v.wd = wd; v.xv = xv; v.xd = xd;
      v.e_step = e_step; v.e_wv = e_wv; v.e_wo = e_wo; v.e_data = e_data;
      v.e_rv = e_rv; v.e_done = e_done; v.e_busy = e_busy;
      return v;
   endfunction

   function automatic logic [N*W-1:0] wrow(input int i);
      logic [W-1:0] e;
      e = W'(i + 1);
      return {N{e}};
   endfunction

   function automatic logic [N*W-1:0] xvec(input int i);
      logic [N*W-1:0] v;
      for (int r = 0; r < N; r++) v[r*W +: W] = W'(4 * i + r + 1);
      return v;
   endfunction

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start_i = 1'b0; vec_cnt_i = '0; abort_i = 1'b0; halt_i = 1'b0;
      w_valid_i = 1'b0; w_data_i = '0; x_valid_i = 1'b0; x_data_i = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".w_ready"}, 64'(w_ready_o), 64'd0);
      chk({tag, ".x_ready"}, 64'(x_ready_o), 64'd0);
      chk({tag, ".wr_wv"}, 64'(wr_weight_v_o), 64'd0);
      chk({tag, ".weight"}, 64'(weight_o), 64'd0);
      chk({tag, ".step"}, 64'(step_o), 64'd0);
      chk({tag, ".data"}, 64'(data_o), 64'd0);
      chk({tag, ".res_valid"}, 64'(res_valid_o), 64'd0);
      chk({tag, ".busy"}, 64'(busy_o), 64'd0);
      chk({tag, ".done"}, 64'(done_o), 64'd0);
      chk({tag, ".state"}, 64'(state_o), 64'(IDLE));
   endtask

   // Runs one job of nvec vectors with optional 5-cycle halts starting at
   // cycles h1/h2, an abort+halt at abort_at and a stray start at restart_at.
   // Cycle 1 is the start cycle; exp_done = 0 means no done pulse expected.
   task automatic run_job(input string tag, input int nvec, input int h1, input int h2,
                          input int abort_at, input int restart_at, input int exp_done);
      int wi, xi, done_cyc, done_n;
      logic in_halt, prev_halt;
      logic [N*W-1:0] prev_data;
      wi = 0; xi = 0; done_cyc = 0; done_n = 0; prev_halt = 1'b0; prev_data = '0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         in_halt   = (h1 > 0 && cyc >= h1 && cyc < h1 + 5) || (h2 > 0 && cyc >= h2 && cyc < h2 + 5);
         start_i   = (cyc == 1) || (cyc == restart_at);
         vec_cnt_i = (cyc == 1) ? CNT_W'(nvec) : CNT_W'(9);
         halt_i    = in_halt || (cyc == abort_at);
         abort_i   = (cyc == abort_at);
         w_valid_i = (wi < N);
         w_data_i  = wrow(wi);
         x_valid_i = (xi < nvec);
         x_data_i  = xvec(xi);
         @(negedge clk);
         if (cyc == 2) chk({tag, ".busy_c2"}, 64'(busy_o), 64'd1);
         if (in_halt) begin
            chk($sformatf("%s.halt_step_c%0d", tag, cyc), 64'(step_o), 64'd0);
            chk($sformatf("%s.halt_xrdy_c%0d", tag, cyc), 64'(x_ready_o), 64'd0);
            chk($sformatf("%s.halt_rv_c%0d", tag, cyc), 64'(res_valid_o), 64'd0);
            if (prev_halt)
               chk($sformatf("%s.halt_data_c%0d", tag, cyc), 64'(data_o), 64'(prev_data));
         end
         if (abort_at > 0 && cyc == abort_at) begin
            chk({tag, ".abort_step"}, 64'(step_o), 64'd0);
            chk({tag, ".abort_busy_before"}, 64'(busy_o), 64'd1);
         end
         if (abort_at > 0 && cyc == abort_at + 1) begin
            chk({tag, ".abort_state"}, 64'(state_o), 64'(IDLE));
            chk({tag, ".abort_data"}, 64'(data_o), 64'd0);
            chk({tag, ".abort_busy"}, 64'(busy_o), 64'd0);
         end
         if (restart_at > 0 && cyc == restart_at)
            chk({tag, ".restart_state"}, 64'(state_o), 64'(STREAM));
         if (done_o) begin
            done_n++;
            if (done_cyc == 0) done_cyc = cyc;
         end
         if (w_valid_i && w_ready_o) wi++;
         if (x_valid_i && x_ready_o) xi++;
         prev_halt = in_halt;
         prev_data = data_o;
         next_cyc();
      end
      idle_inputs();
      chk({tag, ".done_cycle"}, 64'(done_cyc), 64'(exp_done));
      chk({tag, ".done_count"}, 64'(done_n), (exp_done > 0) ? 64'd1 : 64'd0);
      chk({tag, ".end_state"}, 64'(state_o), 64'(IDLE));
   endtask

   initial begin
      logic [31:0] r0, r1, r2, r3, v1, v2, v3;
      r0 = wrow(0); r1 = wrow(1); r2 = wrow(2); r3 = wrow(3);
      v1 = 32'h04030201; v2 = 32'h08070605; v3 = 32'h0C0B0A09;

      //            start wv wd  xv xd  step wv       wo  data          rv       done busy
      tbl[0]  = mk(1, 0, 0,  0, 0,  0, 4'b0000, 0,  32'h0,        4'b0000, 0, 0);
      tbl[1]  = mk(0, 1, r0, 0, 0,  0, 4'b0000, 0,  32'h0,        4'b0000, 0, 1);
      tbl[2]  = mk(0, 1, r1, 0, 0,  0, 4'b0001, r0, 32'h0,        4'b0000, 0, 1);
      tbl[3]  = mk(0, 1, r2, 0, 0,  0, 4'b0010, r1, 32'h0,        4'b0000, 0, 1);
      tbl[4]  = mk(0, 1, r3, 0, 0,  0, 4'b0100, r2, 32'h0,        4'b0000, 0, 1);
      tbl[5]  = mk(0, 0, 0,  1, v1, 0, 4'b1000, r3, 32'h00000001, 4'b0000, 0, 1);
      tbl[6]  = mk(0, 0, 0,  1, v1, 1, 4'b0000, 0,  32'h00000001, 4'b0000, 0, 1);
      tbl[7]  = mk(0, 0, 0,  1, v2, 1, 4'b0000, 0,  32'h00000205, 4'b0000, 0, 1);
      tbl[8]  = mk(0, 0, 0,  1, v3, 1, 4'b0000, 0,  32'h00030609, 4'b0000, 0, 1);
      tbl[9]  = mk(0, 0, 0,  0, 0,  1, 4'b0000, 0,  32'h04070A00, 4'b0000, 0, 1);
      tbl[10] = mk(0, 0, 0,  0, 0,  1, 4'b0000, 0,  32'h080B0000, 4'b1000, 0, 1);
      tbl[11] = mk(0, 0, 0,  0, 0,  1, 4'b0000, 0,  32'h0C000000, 4'b1100, 0, 1);
      tbl[12] = mk(0, 0, 0,  0, 0,  1, 4'b0000, 0,  32'h0,        4'b1110, 0, 1);
      tbl[13] = mk(0, 0, 0,  0, 0,  1, 4'b0000, 0,  32'h0,        4'b0111, 0, 1);
      tbl[14] = mk(0, 0, 0,  0, 0,  1, 4'b0000, 0,  32'h0,        4'b0011, 0, 1);
      tbl[15] = mk(0, 0, 0,  0, 0,  1, 4'b0000, 0,  32'h0,        4'b0001, 0, 1);
      tbl[16] = mk(0, 0, 0,  0, 0,  0, 4'b0000, 0,  32'h0,        4'b0000, 1, 1);
      tbl[17] = mk(0, 0, 0,  0, 0,  0, 4'b0000, 0,  32'h0,        4'b0000, 0, 0);

      // clock/reset
      rst_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      chk_all_zero("reset");
      next_cyc();
      rst_n = 1'b1;
      next_cyc();

      // full job, one table row per cycle starting at the start cycle
      for (int i = 0; i < 18; i++) begin
         start_i   = tbl[i].start;
         vec_cnt_i = CNT_W'(3);
         w_valid_i = tbl[i].wv;
         w_data_i  = tbl[i].wd;
         x_valid_i = tbl[i].xv;
         x_data_i  = tbl[i].xd;
         @(negedge clk);
         chk($sformatf("tbl%0d.step", i), 64'(step_o), 64'(tbl[i].e_step));
         chk($sformatf("tbl%0d.wr_wv", i), 64'(wr_weight_v_o), 64'(tbl[i].e_wv));
         chk($sformatf("tbl%0d.weight", i), 64'(weight_o), 64'(tbl[i].e_wo));
         chk($sformatf("tbl%0d.data", i), 64'(data_o), 64'(tbl[i].e_data));
         chk($sformatf("tbl%0d.res_valid", i), 64'(res_valid_o), 64'(tbl[i].e_rv));
         chk($sformatf("tbl%0d.done", i), 64'(done_o), 64'(tbl[i].e_done));
         chk($sformatf("tbl%0d.busy", i), 64'(busy_o), 64'(tbl[i].e_busy));
         next_cyc();
      end
      idle_inputs();
      repeat (3) next_cyc();

      // reset asserted mid-STREAM, then a one-vector job
      start_i = 1'b1; vec_cnt_i = CNT_W'(3);
      w_valid_i = 1'b1; w_data_i = wrow(0); x_valid_i = 1'b1; x_data_i = xvec(0);
      next_cyc();
      start_i = 1'b0;
      repeat (6) next_cyc();
      @(negedge clk);
      chk("midrst.step_before", 64'(step_o), 64'd1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      next_cyc();
      rst_n = 1'b1;
      idle_inputs();
      next_cyc();
      run_job("after_rst", 1, 0, 0, 0, 0, 15);

      // plain three-vector job, and one with a stray start mid-STREAM
      run_job("plain3", 3, 0, 0, 0, 0, 17);
      run_job("restart", 3, 0, 0, 0, 8, 17);

      // two five-cycle halts, one in STREAM and one in DRAIN
      run_job("halt", 3, 8, 17, 0, 0, 27);

      // abort together with halt in DRAIN
      run_job("abort", 1, 0, 0, 10, 0, 0);

      // zero-length start is ignored
      start_i = 1'b1; vec_cnt_i = '0;
      @(negedge clk);
      next_cyc();
      idle_inputs();
      @(negedge clk);
      chk("zero.state", 64'(state_o), 64'(IDLE));
      chk("zero.busy", 64'(busy_o), 64'd0);
      next_cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
